// File: rtl/mdu_pkg.sv
// Shared opcode and state encodings for the multiply/divide-unit controller.
package mdu_pkg;

    localparam logic [2:0] OP_MULT  = 3'b000;
    localparam logic [2:0] OP_MULTU = 3'b001;
    localparam logic [2:0] OP_MFHI  = 3'b010;
    localparam logic [2:0] OP_MFLO  = 3'b011;
    localparam logic [2:0] OP_MTHI  = 3'b100;
    localparam logic [2:0] OP_MTLO  = 3'b101;

    localparam logic [0:0] ST_IDLE     = 1'b0;
    localparam logic [0:0] ST_MUL_WAIT = 1'b1;

    // 110/111 are reserved and never stall or touch HI/LO.
    function automatic logic is_mdu_op(input logic [2:0] op);
        return op <= OP_MTLO;
    endfunction

endpackage

// File: rtl/mdu_controller_mult.sv
// Combinational Bits x Bits multiplier; uns selects zero- vs sign-extension.
module mdu_controller_mult #(
    parameter int Bits = 32
) (
    input  logic [Bits-1:0]   a,
    input  logic [Bits-1:0]   b,
    input  logic              uns,
    output logic [2*Bits-1:0] product
);

    logic a_ext, b_ext;
    logic [2*Bits-1:0] a_w, b_w;

    // The low 2*Bits of the product of the extended operands is exact for both signed and unsigned.
    assign a_ext   = ~uns & a[Bits-1];
    assign b_ext   = ~uns & b[Bits-1];
    assign a_w     = {{Bits{a_ext}}, a};
    assign b_w     = {{Bits{b_ext}}, b};
    assign product = a_w * b_w;

endmodule

// File: rtl/mdu_controller.sv
// HI/LO owner: sequences a multi-cycle multiply and stalls colliding MDU ops.
module mdu_controller
    import mdu_pkg::*;
#(
    parameter int Bits        = 32,
    parameter int MUL_LATENCY = 4
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            op_valid,
    input  logic [2:0]      op_code,
    input  logic [Bits-1:0] rs_data,
    input  logic [Bits-1:0] rt_data,
    output logic            stall,
    output logic [Bits-1:0] rd_data,
    output logic            busy,
    output logic [Bits-1:0] hi,
    output logic [Bits-1:0] lo
);

    localparam logic [3:0] CNT_INIT = 4'(MUL_LATENCY - 1);

    logic [0:0]        state;
    logic [3:0]        cnt;
    logic [Bits-1:0]   op_a, op_b;
    logic              op_uns;
    logic [2*Bits-1:0] product;

    mdu_controller_mult #(.Bits(Bits)) u_mult (
        .a       (op_a),
        .b       (op_b),
        .uns     (op_uns),
        .product (product)
    );

    assign stall = op_valid & is_mdu_op(op_code) & (state == ST_MUL_WAIT);

    always_comb begin
        rd_data = '0;
        if (op_valid && !stall) begin
            if (op_code == OP_MFHI)      rd_data = hi;
            else if (op_code == OP_MFLO) rd_data = lo;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= ST_IDLE;
            cnt    <= '0;
            busy   <= 1'b0;
            hi     <= '0;
            lo     <= '0;
            op_a   <= '0;
            op_b   <= '0;
            op_uns <= 1'b0;
        end else if (state == ST_IDLE) begin
            if (op_valid) begin
                case (op_code)
                    OP_MULT, OP_MULTU: begin
                        op_a   <= rs_data;
                        op_b   <= rt_data;
                        op_uns <= op_code[0];
                        cnt    <= CNT_INIT;
                        state  <= ST_MUL_WAIT;
                        busy   <= 1'b1;
                    end
                    OP_MTHI: hi <= rs_data;
                    OP_MTLO: lo <= rs_data;
                    default: ;
                endcase
            end
        end else begin
            // Result lands on the edge closing the MUL_LATENCY-th wait cycle.
            if (cnt != '0) begin
                cnt <= cnt - 4'd1;
            end else begin
                hi    <= product[2*Bits-1:Bits];
                lo    <= product[Bits-1:0];
                state <= ST_IDLE;
                busy  <= 1'b0;
            end
        end
    end

endmodule
